cpu_traffic_gen: RTL and testbench

CPU_TRAFFIC_GEN -- requirements
Module: cpu_traffic_gen

---
 rtl/cpu_traffic_gen.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_cpu_traffic_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_traffic_gen.sv
// CPU-side traffic generator for cache testing.
// Writes a run of N addresses, drains briefly, then reads every address back
// and checks the data. Errors are counted (mismatch or response timeout) and
// the address of the first failure is kept. Address patterns: sequential,
// line stride, LFSR-random inside a window, and same-set eviction.
module cpu_traffic_gen #(
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter int          NUM_REQ  = 64,
   parameter logic [31:0] LO       = 32'd0,
   parameter int          RANGE_W  = 14,
   parameter int          OFFSET_W = 6,
   parameter int          INDEX_W  = 6,
   parameter int          WAYS     = 4,
   parameter logic [31:0] SEED     = 32'hACE1_0001,
   parameter logic [31:0] PATTERN  = 32'h0F0F_0000,
   parameter int          TIMEOUT  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              req_valid,
   output logic              req_we,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              req_ready,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_READ  = 3'd3,
      ST_RWAIT = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [1:0]        MODE_SEQ    = 2'd0;
   localparam logic [1:0]        MODE_STRIDE = 2'd1;
   localparam logic [1:0]        MODE_RAND   = 2'd2;
   localparam logic [1:0]        MODE_EVICT  = 2'd3;
   // Galois form of x^32 + x^22 + x^2 + x + 1 (right-shifting).
   localparam logic [31:0]       LFSR_TAPS   = 32'h8020_0003;
   localparam int                RB_W        = RANGE_W - 2;
   localparam logic [RB_W-1:0]   SEED_RBITS  = SEED[RANGE_W-1:2];
   localparam logic [15:0]       N_MAIN      = 16'(NUM_REQ);
   localparam logic [15:0]       N_EVICT     = 16'(WAYS + 1);
   localparam int                TMO_W       = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT - 1);
   localparam int                XW          = (ADDR_W > 32) ? ADDR_W : 32;

   // One step of the address LFSR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
      logic [31:0] nxt;
      if (cur[0]) begin
         nxt = (cur >> 1) ^ LFSR_TAPS;
      end else begin
         nxt = cur >> 1;
      end
      return nxt;
   endfunction

   // Address of request k for the given mode; rbits are LFSR bits [RANGE_W-1:2].
   function automatic logic [ADDR_W-1:0] gen_addr(input logic [1:0] m,
                                                  input logic [15:0] k,
                                                  input logic [RB_W-1:0] rbits);
      logic [ADDR_W-1:0] a;
      case (m)
         MODE_SEQ:    a = ADDR_W'(LO) + ADDR_W'({k, 2'b00});
         MODE_STRIDE: a = ADDR_W'(LO) + (ADDR_W'(k) << OFFSET_W);
         MODE_RAND:   a = ADDR_W'(LO) + ADDR_W'({rbits, 2'b00});
         MODE_EVICT:  a = ((ADDR_W'(k) + ADDR_W'(32'd1)) << (OFFSET_W + INDEX_W))
                          | ADDR_W'(32'h10);
         default:     a = '0;
      endcase
      return a;
   endfunction

   // Write data is a pure function of the address so rewrites stay consistent.
   function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
      logic [XW-1:0] x;
      x = XW'(a) ^ XW'(PATTERN);
      return DATA_W'(x);
   endfunction

   state_t            state_r, state_s;
   logic [1:0]        mode_r, mode_s;
   logic [15:0]       k_r, k_s;
   logic [31:0]       lfsr_r, lfsr_s;
   logic [2:0]        drain_r, drain_s;
   logic [TMO_W-1:0]  tmo_r, tmo_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              pass_r, pass_s;
   logic [15:0]       err_r, err_s;
   logic [ADDR_W-1:0] ferr_r, ferr_s;
   logic              vld_r, vld_s;
   logic              we_r, we_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;

   logic [15:0]       n_req_s;
   logic [15:0]       k_inc_s;
   logic [31:0]       lfsr_stp_s;
   logic [ADDR_W-1:0] wr_next_addr_s;
   logic [ADDR_W-1:0] rd_next_addr_s;
   logic [ADDR_W-1:0] start_addr_s;
   logic [ADDR_W-1:0] read0_addr_s;
   logic [15:0]       err_inc_s;
   logic              rsp_done_s;
   logic              rsp_fail_s;

   // Next-state and next-output logic for the run sequencer.
   always_comb begin
      state_s = state_r;
      mode_s  = mode_r;
      k_s     = k_r;
      lfsr_s  = lfsr_r;
      drain_s = drain_r;
      tmo_s   = tmo_r;
      busy_s  = busy_r;
      done_s  = done_r;
      pass_s  = pass_r;
      err_s   = err_r;
      ferr_s  = ferr_r;
      vld_s   = vld_r;
      we_s    = we_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;

      n_req_s        = (mode_r == MODE_EVICT) ? N_EVICT : N_MAIN;
      k_inc_s        = k_r + 16'd1;
      lfsr_stp_s     = lfsr_step(lfsr_r);
      wr_next_addr_s = gen_addr(mode_r, k_inc_s, lfsr_stp_s[RANGE_W-1:2]);
      rd_next_addr_s = gen_addr(mode_r, k_r, lfsr_r[RANGE_W-1:2]);
      start_addr_s   = gen_addr(mode, 16'd0, SEED_RBITS);
      read0_addr_s   = gen_addr(mode_r, 16'd0, SEED_RBITS);
      err_inc_s      = (err_r == 16'hFFFF) ? err_r : (err_r + 16'd1);
      rsp_done_s     = 1'b0;
      rsp_fail_s     = 1'b0;

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = ST_WRITE;
               mode_s  = mode;
               k_s     = 16'd0;
               lfsr_s  = SEED;
               busy_s  = 1'b1;
               done_s  = 1'b0;
               pass_s  = 1'b0;
               err_s   = 16'd0;
               ferr_s  = '0;
               vld_s   = 1'b1;
               we_s    = 1'b1;
               addr_s  = start_addr_s;
               wdata_s = data_of(start_addr_s);
            end else begin
               state_s = state_r;
            end
         end
         ST_WRITE: begin
            if (vld_r && req_ready) begin
               k_s    = k_inc_s;
               lfsr_s = lfsr_stp_s;
               if (k_inc_s == n_req_s) begin
                  state_s = ST_DRAIN;
                  vld_s   = 1'b0;
                  we_s    = 1'b0;
                  drain_s = 3'd0;
               end else begin
                  addr_s  = wr_next_addr_s;
                  wdata_s = data_of(wr_next_addr_s);
               end
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_DRAIN: begin
            if (drain_r == 3'd4) begin
               // Replay the write sequence from the seed.
               state_s = ST_READ;
               k_s     = 16'd0;
               lfsr_s  = SEED;
               vld_s   = 1'b1;
               we_s    = 1'b0;
               addr_s  = read0_addr_s;
               wdata_s = '0;
            end else begin
               drain_s = drain_r + 3'd1;
            end
         end
         ST_READ: begin
            if (vld_r && req_ready) begin
               state_s = ST_RWAIT;
               vld_s   = 1'b0;
               tmo_s   = '0;
               k_s     = k_inc_s;
               lfsr_s  = lfsr_stp_s;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_RWAIT: begin
            if (rsp_valid) begin
               rsp_done_s = 1'b1;
               rsp_fail_s = (rsp_rdata != data_of(addr_r));
            end else if (tmo_r == TMO_LAST) begin
               rsp_done_s = 1'b1;
               rsp_fail_s = 1'b1;
            end else begin
               tmo_s = tmo_r + TMO_W'(1);
            end

            if (rsp_fail_s) begin
               err_s = err_inc_s;
               if (err_r == 16'd0) begin
                  ferr_s = addr_r;
               end else begin
                  ferr_s = ferr_r;
               end
            end else begin
               err_s = err_r;
            end

            if (rsp_done_s) begin
               if (k_r == n_req_s) begin
                  state_s = ST_DONE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  pass_s  = (err_s == 16'd0);
               end else begin
                  state_s = ST_READ;
                  vld_s   = 1'b1;
                  addr_s  = rd_next_addr_s;
               end
            end else begin
               state_s = ST_RWAIT;
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            vld_s   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         mode_r  <= 2'd0;
         k_r     <= 16'd0;
         lfsr_r  <= SEED;
         drain_r <= 3'd0;
         tmo_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         err_r   <= 16'd0;
         ferr_r  <= '0;
         vld_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
      end else begin
         state_r <= state_s;
         mode_r  <= mode_s;
         k_r     <= k_s;
         lfsr_r  <= lfsr_s;
         drain_r <= drain_s;
         tmo_r   <= tmo_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         pass_r  <= pass_s;
         err_r   <= err_s;
         ferr_r  <= ferr_s;
         vld_r   <= vld_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign err_count      = err_r;
   assign first_err_addr = ferr_r;
   assign req_valid      = vld_r;
   assign req_we         = we_r;
   assign req_addr       = addr_r;
   assign req_wdata      = wdata_r;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// Directed bench for cpu_traffic_gen with a small cache responder.
module tb_cpu_traffic_gen;

   localparam int          N     = 16;
   localparam logic [31:0] PAT   = 32'h0F0F_0000;
   localparam logic [31:0] SEEDV = 32'hACE1_0001;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [31:0] first_err_addr;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   always #5 clk = ~clk;

   cpu_traffic_gen #(
      .NUM_REQ(N), .OFFSET_W(8), .INDEX_W(8), .WAYS(4), .TIMEOUT(256)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_cnt = 0;

   // responder knobs and state
   bit          stall_en = 1'b0;
   bit          block_ready = 1'b0;
   int          corrupt_idx = -1;
   int          withhold_idx = -1;
   bit          wh_fired = 1'b0;
   int          wh_acc = 0;
   int          read_idx = 0;
   bit          pend_read = 1'b0;
   logic [31:0] pend_addr;
   int          pend_idx = 0;
   int          stall_left = 0;
   bit          hold_prev = 1'b0;
   logic [31:0] h_addr, h_wdata;
   logic        h_we;
   bit [31:0]   mem [bit [31:0]];
   logic [31:0] log_addr[$];
   logic        log_we[$];
   logic [31:0] log_wdata[$];

   // posedge counter used to time the response timeout
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] la(input int i);
      return (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [31:0] lw(input int i);
      return (i < log_we.size()) ? {31'd0, log_we[i]} : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [31:0] lwd(input int i);
      return (i < log_wdata.size()) ? log_wdata[i] : 32'hxxxx_xxxx;
   endfunction

   // expected address of request k: LO=0, OFFSET_W=8, INDEX_W=8, RANGE_W=14
   function automatic logic [31:0] model_addr(input logic [1:0] m, input int k);
      logic [31:0] l;
      logic [31:0] a;
      l = SEEDV;
      for (int j = 0; j < k; j++) begin
         l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
      end
      case (m)
         2'd0:    a = 32'(k) * 32'd4;
         2'd1:    a = 32'(k) * 32'd256;
         2'd2:    a = l & 32'h0000_3FFC;
         default: a = (32'(k + 1) << 16) | 32'h0000_0010;
      endcase
      return a;
   endfunction

   task automatic check_seq(input logic [1:0] m, input int n, input string tag);
      chk({tag, "_count"}, 32'(log_addr.size()), 32'(2 * n));
      for (int i = 0; i < 2 * n; i++) begin
         logic [31:0] ea;
         ea = model_addr(m, i % n);
         chk($sformatf("%s_addr%0d", tag, i), la(i), ea);
         chk($sformatf("%s_we%0d", tag, i), lw(i), (i < n) ? 32'd1 : 32'd0);
         if (i < n) chk($sformatf("%s_wdata%0d", tag, i), lwd(i), ea ^ PAT);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_wdata.delete();
      read_idx = 0;
      wh_fired = 1'b0;
   endtask

   task automatic run(input logic [1:0] m, input int poke, output int cycles);
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      while (done !== 1'b1 && cycles < 5000) begin
         @(negedge clk);
         cycles++;
         if (cycles == poke) begin
            start = 1'b1;
            mode  = 2'd0;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("run_reaches_done", {31'd0, done}, 32'd1);
   endtask

   // Cache model: drives inputs at negedge, logs the transfer of the coming posedge.
   initial begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (hold_prev && !reset) begin
            chk("hold_valid", {31'd0, req_valid}, 32'd1);
            chk("hold_we", {31'd0, req_we}, {31'd0, h_we});
            chk("hold_addr", req_addr, h_addr);
            chk("hold_wdata", req_wdata, h_wdata);
         end
         rsp_valid = 1'b0;
         if (reset) pend_read = 1'b0;
         if (pend_read) begin
            pend_read = 1'b0;
            if (pend_idx != withhold_idx) begin
               rsp_valid = 1'b1;
               rsp_rdata = mem[pend_addr] ^ ((pend_idx == corrupt_idx) ? 32'd1 : 32'd0);
            end
         end
         if (block_ready) req_ready = 1'b0;
         else if (!stall_en) req_ready = 1'b1;
         else if (stall_left > 0) begin
            req_ready = 1'b0;
            stall_left--;
         end else req_ready = 1'b1;
         hold_prev = stall_en && req_valid && !req_ready && !reset;
         h_addr  = req_addr;
         h_wdata = req_wdata;
         h_we    = req_we;
         if (req_valid && req_ready && !reset) begin
            log_addr.push_back(req_addr);
            log_we.push_back(req_we);
            log_wdata.push_back(req_wdata);
            if (req_we) mem[req_addr] = req_wdata;
            else begin
               pend_read = 1'b1;
               pend_addr = req_addr;
               pend_idx  = read_idx;
               if (read_idx == withhold_idx) begin
                  wh_fired = 1'b1;
                  wh_acc   = cyc_cnt + 1;
               end
               read_idx++;
            end
            if (stall_en) stall_left = $urandom_range(0, 7);
         end
      end
   end

   // Directed test sequence.
   initial begin
      int cyc;
      int guard;
      reset = 1'b1;
      start = 1'b0;
      mode  = 2'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_pass", {31'd0, pass}, 32'd0);
      chk("rst_err", {16'd0, err_count}, 32'd0);
      chk("rst_ferr", first_err_addr, 32'd0);
      chk("rst_valid", {31'd0, req_valid}, 32'd0);
      chk("rst_we", {31'd0, req_we}, 32'd0);
      chk("rst_addr", req_addr, 32'd0);
      chk("rst_wdata", req_wdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // SEQ, ideal cache
      clear_log();
      run(2'd0, -1, cyc);
      chk("seq_cycles", 32'(cyc), 32'd54);
      chk("seq_pass", {31'd0, pass}, 32'd1);
      chk("seq_err", {16'd0, err_count}, 32'd0);
      chk("seq_busy", {31'd0, busy}, 32'd0);
      chk("seq_w15_addr", la(15), 32'h0000_003C);
      chk("seq_w15_data", lwd(15), 32'h0F0F_003C);
      check_seq(2'd0, N, "seq");
      repeat (3) @(negedge clk);
      chk("seq_done_held", {31'd0, done}, 32'd1);
      chk("seq_pass_held", {31'd0, pass}, 32'd1);

      // EVICT: five tags in set 0
      clear_log();
      run(2'd3, -1, cyc);
      chk("evict_first", la(0), 32'h0001_0010);
      chk("evict_last_w", la(4), 32'h0005_0010);
      chk("evict_last_r", la(9), 32'h0005_0010);
      chk("evict_pass", {31'd0, pass}, 32'd1);
      check_seq(2'd3, 5, "evict");

      // RAND with the third read corrupted
      clear_log();
      corrupt_idx = 2;
      run(2'd2, -1, cyc);
      corrupt_idx = -1;
      chk("rand_w3_addr", la(3), 32'h0000_2000);
      chk("rand_err", {16'd0, err_count}, 32'd1);
      chk("rand_ferr", first_err_addr, la(2));
      chk("rand_ferr_abs", first_err_addr, 32'h0000_0000);
      chk("rand_pass", {31'd0, pass}, 32'd0);
      check_seq(2'd2, N, "rand");

      // STRIDE with ready stalls; a start pulse mid-run must be ignored
      clear_log();
      stall_en = 1'b1;
      run(2'd1, 10, cyc);
      stall_en = 1'b0;
      chk("stride_w1_addr", la(1), 32'h0000_0100);
      chk("stride_pass", {31'd0, pass}, 32'd1);
      check_seq(2'd1, N, "stride");

      // SEQ with read 5 never answered
      clear_log();
      withhold_idx = 5;
      @(negedge clk);
      mode  = 2'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!wh_fired && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      chk("tmo_read_accepted", {31'd0, wh_fired}, 32'd1);
      guard = 0;
      while (cyc_cnt < wh_acc + 255 && guard < 600) begin
         @(negedge clk);
         guard++;
      end
      chk("tmo_err_before", {16'd0, err_count}, 32'd0);
      @(negedge clk);
      chk("tmo_err_at_256", {16'd0, err_count}, 32'd1);
      guard = 0;
      while (done !== 1'b1 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      withhold_idx = -1;
      chk("tmo_done", {31'd0, done}, 32'd1);
      chk("tmo_err_final", {16'd0, err_count}, 32'd1);
      chk("tmo_ferr", first_err_addr, 32'h0000_0014);
      chk("tmo_pass", {31'd0, pass}, 32'd0);
      chk("tmo_count", 32'(log_addr.size()), 32'd32);

      // Reset while a read is held in READ, then rerun from the seed
      clear_log();
      @(negedge clk);
      mode  = 2'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (read_idx < 4 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      block_ready = 1'b1;
      guard = 0;
      while (!(req_valid === 1'b1 && req_we === 1'b0 && rsp_valid === 1'b0) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      repeat (2) @(negedge clk);
      chk("rr_in_read_valid", {31'd0, req_valid}, 32'd1);
      chk("rr_in_read_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rr_busy", {31'd0, busy}, 32'd0);
      chk("rr_valid", {31'd0, req_valid}, 32'd0);
      chk("rr_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      block_ready = 1'b0;
      @(negedge clk);
      clear_log();
      run(2'd2, -1, cyc);
      chk("rr_pass", {31'd0, pass}, 32'd1);
      chk("rr_err", {16'd0, err_count}, 32'd0);
      check_seq(2'd2, N, "rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
